// File: rtl/spis_mbuf_reg.sv
`default_nettype none
// ============================================================================
// Module   : spis_mbuf_reg (with helper spis_mbuf_fifo)
// Purpose  : Multi-channel SPI-slave CMD/STATUS registers, command FSM and
//            per-channel write/read FIFOs between the SPI shifter and the
//            AVMM bridge. Define SPIS_MBUF_BURST_CHK_EN to check the wbuf
//            fill level against brstlen when a write command starts.
// Revision : 1.0 - initial release
// ============================================================================

module spis_mbuf_fifo #(
   parameter int DEPTH = 64,
   parameter int LVL_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [31:0]      wdata,
   output logic [31:0]      head,
   output logic [LVL_W-1:0] level,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   // A pop frees the slot, so a push into a full FIFO in the same cycle is kept.
   assign do_pop  = pop && !flush && !empty;
   assign do_push = push && !flush && (!full || do_pop);
   assign ovf     = push && !flush && full && !do_pop;
   assign unf     = pop && !flush && empty;
   assign head    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end
endmodule

module spis_mbuf_reg #(
   parameter int NCH        = 4,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        s_avmm_clk,
   input  logic        s_avmm_rst,
   input  logic        spi_write,
   input  logic        spi_read,
   input  logic [15:0] spi_addr,
   input  logic [31:0] mosi_data,
   output logic [31:0] miso_data,
   output logic        miso_vld,
   input  logic        frame_end,
   input  logic        avb2reg_write,
   input  logic [31:0] avb2reg_rdata,
   input  logic        avb2reg_read,
   output logic [31:0] reg2avb_wdata,
   output logic [7:0]  avmm_brstlen,
   output logic [1:0]  avmm_sel,
   output logic [16:0] avmm_offset,
   output logic        avmm_rdnwr,
   output logic        avmm_transvld,
   input  logic        avmmtransvld_up
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t      state;
   logic [31:0] cmd;
   logic        rbuf_pend;
   logic [3:0]  wovf_s, wunf_s, rovf_s, runf_s;
   logic        len_err;
   logic [1:0]  sel;

   logic             is_cmd, is_status, is_fifoctl, is_level, in_push, in_pop;
   logic             cmd_wr, fifoctl_wr, clr_all, push_win, pop_win;
   logic             wr_done, pend_flush, start_req, len_bad;
   logic [31:0]      status, rd_val;
   logic [31:0]      wb_head [4];
   logic [31:0]      rb_head [4];
   logic [LVL_W-1:0] wb_lvl  [4];
   logic [LVL_W-1:0] rb_lvl  [4];
   logic [3:0]       wb_empty, rb_empty;
   logic [3:0]       wb_ovf_ev, wb_unf_ev, rb_ovf_ev, rb_unf_ev;

   assign sel        = cmd[20:19];
   assign is_cmd     = (spi_addr == 16'h0000);
   assign is_status  = (spi_addr == 16'h0004);
   assign is_fifoctl = (spi_addr == 16'h0008);
   assign is_level   = (spi_addr == 16'h000C);
   assign in_push    = (spi_addr >= 16'h0200) && (spi_addr <= 16'h09FF);
   assign in_pop     = (spi_addr >= 16'h1000) && (spi_addr <= 16'h17FF);
   assign cmd_wr     = spi_write && is_cmd;
   assign fifoctl_wr = spi_write && is_fifoctl;
   assign clr_all    = fifoctl_wr && mosi_data[16];
   assign push_win   = spi_write && in_push;
   assign pop_win    = spi_read && in_pop;
   assign wr_done    = (state == ACTIVE) && avmmtransvld_up && !cmd[1];
   assign pend_flush = (state == IDLE) && rbuf_pend && frame_end && (cmd[31:24] != 8'd1);
   assign start_req  = cmd_wr && (state == IDLE) && mosi_data[0];

`ifdef SPIS_MBUF_BURST_CHK_EN
   logic [8:0] exp_len;
   // brstlen of 0 encodes a 256-word burst.
   assign exp_len = (mosi_data[31:24] == 8'd0) ? 9'd256 : {1'b0, mosi_data[31:24]};
   assign len_bad = !mosi_data[1] && (32'(wb_lvl[mosi_data[20:19]]) != 32'(exp_len));
`else
   assign len_bad = 1'b0;
`endif

   for (genvar c = 0; c < 4; c++) begin : g_ch
      localparam logic [1:0] CH = 2'(c);
      if (c < NCH) begin : g_on
         logic csel;
         assign csel = (sel == CH);

         spis_mbuf_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_wbuf (
            .clk   (s_avmm_clk),
            .rst   (s_avmm_rst),
            .flush ((fifoctl_wr && mosi_data[c]) || (wr_done && csel)),
            .push  (push_win && csel),
            .pop   (avb2reg_read && csel),
            .wdata (mosi_data),
            .head  (wb_head[c]),
            .level (wb_lvl[c]),
            .empty (wb_empty[c]),
            .ovf   (wb_ovf_ev[c]),
            .unf   (wb_unf_ev[c])
         );

         spis_mbuf_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rbuf (
            .clk   (s_avmm_clk),
            .rst   (s_avmm_rst),
            .flush ((fifoctl_wr && mosi_data[8+c]) || (pend_flush && csel)),
            .push  (avb2reg_write && csel),
            .pop   (pop_win && csel),
            .wdata (avb2reg_rdata),
            .head  (rb_head[c]),
            .level (rb_lvl[c]),
            .empty (rb_empty[c]),
            .ovf   (rb_ovf_ev[c]),
            .unf   (rb_unf_ev[c])
         );
      end else begin : g_off
         assign wb_head[c]   = 32'd0;
         assign rb_head[c]   = 32'd0;
         assign wb_lvl[c]    = '0;
         assign rb_lvl[c]    = '0;
         assign wb_empty[c]  = 1'b1;
         assign rb_empty[c]  = 1'b1;
         assign wb_ovf_ev[c] = 1'b0;
         assign wb_unf_ev[c] = 1'b0;
         assign rb_ovf_ev[c] = 1'b0;
         assign rb_unf_ev[c] = 1'b0;
      end
   end

   assign status = {(state == ACTIVE), len_err, 2'b00, runf_s, 4'd0, rovf_s,
                    4'd0, wunf_s, 4'd0, wovf_s};

   always_comb begin
      rd_val = 32'd0;
      if (is_cmd)          rd_val = cmd;
      else if (is_status)  rd_val = status;
      else if (is_level)   rd_val = {16'(rb_lvl[sel]), 16'(wb_lvl[sel])};
      else if (in_pop)     rd_val = rb_empty[sel] ? 32'hDEADBEEF : rb_head[sel];
   end

   assign reg2avb_wdata = wb_empty[sel] ? 32'd0 : wb_head[sel];
   assign avmm_brstlen  = cmd[31:24];
   assign avmm_sel      = cmd[20:19];
   assign avmm_offset   = cmd[18:2];
   assign avmm_rdnwr    = cmd[1];
   assign avmm_transvld = cmd[0];

   always_ff @(posedge s_avmm_clk) begin
      if (s_avmm_rst) begin
         miso_data <= 32'd0;
         miso_vld  <= 1'b0;
      end else begin
         miso_vld <= spi_read;
         if (spi_read) miso_data <= rd_val;
      end
   end

   // Set events take priority over a coincident clear-all.
   always_ff @(posedge s_avmm_clk) begin
      if (s_avmm_rst) begin
         wovf_s  <= 4'd0;
         wunf_s  <= 4'd0;
         rovf_s  <= 4'd0;
         runf_s  <= 4'd0;
         len_err <= 1'b0;
      end else begin
         wovf_s  <= (clr_all ? 4'd0 : wovf_s) | wb_ovf_ev;
         wunf_s  <= (clr_all ? 4'd0 : wunf_s) | wb_unf_ev;
         rovf_s  <= (clr_all ? 4'd0 : rovf_s) | rb_ovf_ev;
         runf_s  <= (clr_all ? 4'd0 : runf_s) | rb_unf_ev;
         len_err <= (clr_all ? 1'b0 : len_err) | (start_req && len_bad);
      end
   end

   always_ff @(posedge s_avmm_clk) begin
      if (s_avmm_rst) begin
         state     <= IDLE;
         cmd       <= 32'd0;
         rbuf_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_end && rbuf_pend) rbuf_pend <= 1'b0;
               if (cmd_wr) begin
                  if (mosi_data[0] && !len_bad) begin
                     cmd   <= mosi_data;
                     state <= ACTIVE;
                  end else begin
                     cmd <= {mosi_data[31:1], 1'b0};
                  end
               end
            end
            ACTIVE: begin
               if (avmmtransvld_up) begin
                  cmd[0] <= 1'b0;
                  state  <= IDLE;
                  if (cmd[1]) rbuf_pend <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire
